pipelined_mac: RTL
==================

Name: pipelined_mac

Overview:
- Parametrised, fully pipelined signed multiply-accumulate unit.
- Accepts one operand pair per cycle with no back-pressure.
- The multiplier is split across MULT_STAGES register stages to meet timing at higher INW.
- Control (valid/init) travels with the data, so accumulator load and accumulate stay cycle-aligned with the operands. Used as the per-lane compute element in the datapath.

Parameters:
INW, 16, operand and init_value width (signed two's complement)
OUTW, 64, accumulator/output width; must satisfy OUTW >= 2*INW
MULT_STAGES, 2, product pipeline registers, legal range 1..4

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high
input0  input  INW  signed multiplicand
input1  input  INW  signed multiplier
init_value  input  INW  signed value loaded into accumulator, sign-extended to OUTW
init_acc  input  1  load init_value into accumulator (takes priority over input_valid)
input_valid  input  1  operand pair valid, accumulate product
out  output  OUTW  signed accumulator value
out_valid  output  1  one-cycle pulse: accumulator updated on the preceding edge
sat_flag  output  1  sticky overflow/saturation indicator (see Optional Feature)

Behaviour:
- Reset is synchronous and active-high, with clock clk. While reset is high on an edge:
  - out=0, out_valid=0, sat_flag=0.
  - All pipeline valid/init bits are cleared. Pipeline data registers may keep stale values.
- Stage 0 (edge k): register input0, input1, init_value, init_acc, input_valid.
- Stages 1..MULT_STAGES (edges k+1..k+MULT_STAGES):
  - Signed product (2*INW bits) is computed and registered.
  - Control bits and init_value are delayed alongside it.
- Accumulate stage (edge k+MULT_STAGES+1):
  - if init: out <= sign-extended init_value.
  - else if valid: out <= out + sign-extended product.
  - else: out holds.
- Latency: inputs sampled on edge k affect out after edge k+MULT_STAGES+1. For MULT_STAGES=2 that is 3 cycles.
- out_valid is high for exactly the cycle after each accumulator update (init or accumulate); otherwise 0.
- Throughput is one operation per cycle. Back-to-back valid cycles produce back-to-back updates; bubbles (valid=0, init=0) leave out unchanged.
- init_acc and input_valid in the same cycle: init wins and that cycle's product is discarded.
- An init in flight behind earlier accumulates: earlier accumulates apply first, in order, then the init overwrites.
- Reset mid-operation: all in-flight operations are dropped. No out_valid pulse is produced for any operation sampled before or during reset.
- Arithmetic: operands are signed. Product is sign-extended to OUTW. The sum wraps modulo 2^OUTW unless MAC_SAT_EN is defined.
- Inputs are "don't care" when input_valid=0 and init_acc=0.

Optional Feature:
- Macro: MAC_SAT_EN.
- Defined:
  - The accumulate result is computed at OUTW+1 bits.
  - On signed overflow, out clamps to 2^(OUTW-1)-1, or to -2^(OUTW-1) on negative overflow.
  - sat_flag sets and stays set until reset or an init_acc load reaches the accumulate stage.
  - Init loads never saturate.
- Not defined:
  - The sum wraps modulo 2^OUTW.
  - sat_flag is tied to 0; the port is still present.

Test Plan:
1. INW=16, OUTW=64, MULT_STAGES=2. Reset, then init_acc=1 with init_value=5 on edge 0 -> out=5 and out_valid=1 after edge 3. out_valid=0 on the following cycle.
2. After init 0, valid pairs (3,4), (-2,7), (100,100) on consecutive edges -> out = 12, -2, 9998 on consecutive cycles, with out_valid high for 3 cycles.
3. Pairs (2,2), bubble, bubble, (5,-1) after init 10 -> out = 14, holds 14 for 2 cycles with out_valid=0, then 9.
4. Same cycle init_acc=1 (init_value=-7) and input_valid=1 (1000,1000) -> out=-7. The product is not added.
5. Issue (3,3) on edge 0, assert reset on edge 1 -> out=0 and out_valid never pulses for (3,3). The next init works normally.
6. OUTW=32, INW=16, init 0, then (32767,32767) three times:
   - MAC_SAT_EN defined -> out=2147483647 and sat_flag=1 after the third update. A subsequent init_acc clears sat_flag.
   - Macro undefined -> out=-1073938429 and sat_flag=0.

Source files
------------

// File: rtl/pipelined_mac.sv
`default_nettype none
// ============================================================================
//  Module   : pipelined_mac
//  Purpose  : Fully pipelined signed multiply-accumulate unit. Accepts one
//             operand pair per cycle with no back-pressure. The product runs
//             through MULT_STAGES registers and the valid/init control bits
//             travel alongside it, so loads and accumulates stay aligned with
//             their operands.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    INW          operand / init_value width (signed)
//    OUTW         accumulator width, OUTW >= 2*INW
//    MULT_STAGES  product pipeline registers, 1..4
//  Build macro
//    MAC_SAT_EN   when defined the accumulator saturates on signed overflow
//                 and sat_flag is a sticky indicator; otherwise the sum wraps
//                 and sat_flag is tied low.
//  Ports
//    clk          clock, rising edge
//    reset        synchronous, active-high
//    input0       signed multiplicand
//    input1       signed multiplier
//    init_value   signed accumulator load value (sign-extended)
//    init_acc     load init_value (wins over input_valid)
//    input_valid  accumulate input0*input1
//    out          signed accumulator value
//    out_valid    high the cycle after each accumulator update
//    sat_flag     sticky saturation indicator
//  Latency: inputs sampled on edge k reach out after edge k+MULT_STAGES+1.
// ============================================================================
module pipelined_mac #(
  parameter int INW         = 16,
  parameter int OUTW        = 64,
  parameter int MULT_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic signed [INW-1:0]  input0,
  input  logic signed [INW-1:0]  input1,
  input  logic signed [INW-1:0]  init_value,
  input  logic                   init_acc,
  input  logic                   input_valid,
  output logic signed [OUTW-1:0] out,
  output logic                   out_valid,
  output logic                   sat_flag
);

  localparam int PW = 2 * INW;

  // Control bits, index 0 = input register, index MULT_STAGES = last product
  // stage feeding the accumulator.
  logic [MULT_STAGES:0]         r_vld;
  logic [MULT_STAGES:0]         r_init;

  // Data pipeline. No reset: stale contents are harmless because every use is
  // qualified by the matching control bit.
  logic signed [INW-1:0]        r_a;
  logic signed [INW-1:0]        r_b;
  logic signed [INW-1:0]        r_ival [0:MULT_STAGES];
  logic signed [PW-1:0]         r_prod [1:MULT_STAGES];

  logic signed [PW-1:0]         w_a_ext;
  logic signed [PW-1:0]         w_b_ext;
  logic signed [PW-1:0]         w_prod;
  logic signed [OUTW-1:0]       w_prod_ext;
  logic signed [OUTW-1:0]       w_init_ext;
  logic signed [OUTW-1:0]       w_acc_next;
  logic                         w_ovf;

  logic signed [OUTW-1:0]       r_acc;
  logic                         r_out_valid;

  // --------------------------------------------------------------------------
  // Control pipeline
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld  <= '0;
      r_init <= '0;
    end else begin
      r_vld  <= {r_vld[MULT_STAGES-1:0],  input_valid};
      r_init <= {r_init[MULT_STAGES-1:0], init_acc};
    end
  end

  // --------------------------------------------------------------------------
  // Data pipeline: operand capture, multiply, then MULT_STAGES-1 further
  // product registers that synthesis can retime into the multiplier.
  // --------------------------------------------------------------------------
  // Operands are widened to the product width first so the multiply is
  // evaluated at exactly PW bits; the low PW bits of the widened product are
  // the exact signed product.
  assign w_a_ext = PW'(r_a);
  assign w_b_ext = PW'(r_b);
  assign w_prod  = w_a_ext * w_b_ext;

  always_ff @(posedge clk) begin
    r_a       <= input0;
    r_b       <= input1;
    r_ival[0] <= init_value;
    r_prod[1] <= w_prod;
    r_ival[1] <= r_ival[0];
    for (int i = 2; i <= MULT_STAGES; i++) begin
      r_prod[i] <= r_prod[i-1];
      r_ival[i] <= r_ival[i-1];
    end
  end

  // --------------------------------------------------------------------------
  // Accumulate stage
  // --------------------------------------------------------------------------
  assign w_prod_ext = OUTW'(r_prod[MULT_STAGES]);
  assign w_init_ext = OUTW'(r_ival[MULT_STAGES]);

`ifdef MAC_SAT_EN
  localparam logic [OUTW-1:0] c_max = {1'b0, {(OUTW-1){1'b1}}};
  localparam logic [OUTW-1:0] c_min = {1'b1, {(OUTW-1){1'b0}}};

  logic [OUTW:0] w_sum;
  logic          r_sat;

  // One guard bit: the two top bits disagree exactly on signed overflow, and
  // the guard bit then gives the true sign of the result.
  assign w_sum = {r_acc[OUTW-1], r_acc} + {w_prod_ext[OUTW-1], w_prod_ext};
  assign w_ovf = w_sum[OUTW] ^ w_sum[OUTW-1];

  always_comb begin
    w_acc_next = w_sum[OUTW-1:0];
    if (w_ovf) begin
      w_acc_next = w_sum[OUTW] ? c_min : c_max;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sat <= 1'b0;
    end else if (r_init[MULT_STAGES]) begin
      r_sat <= 1'b0;
    end else if (r_vld[MULT_STAGES] && w_ovf) begin
      r_sat <= 1'b1;
    end
  end

  assign sat_flag = r_sat;
`else
  assign w_ovf      = 1'b0;
  assign w_acc_next = r_acc + w_prod_ext;
  assign sat_flag   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_init[MULT_STAGES] | r_vld[MULT_STAGES];
      // Init has priority; a product travelling with an init is discarded.
      if (r_init[MULT_STAGES]) begin
        r_acc <= w_init_ext;
      end else if (r_vld[MULT_STAGES]) begin
        r_acc <= w_acc_next;
      end
    end
  end

  assign out       = r_acc;
  assign out_valid = r_out_valid;

endmodule
`default_nettype wire
